mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX directly downstream of the main `controller`. It consumes the 6-bit `ALUSelect` code the controller passes through for R-type instructions and executes mult/multu/div/divu iteratively. It executes mthi/mtlo in one cycle. It serves mfhi/mflo reads and raises a stall while an iterative operation is in flight.

## Interface
- `WIDTH`, default 32, operand/HI/LO width; only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start_in` in 1: EX-stage instruction valid this cycle.
- `ALUSelect_in` in 6: function code from `controller` `ALUSelect_out`.
- `rs_in` in 32: operand A (dividend, multiplicand, or mthi/mtlo source).
- `rt_in` in 32: operand B (divisor or multiplier).
- `result_out` out 32: HI when code is 010000 (mfhi), LO when 010010 (mflo), else 0; combinational from the registers.
- `hi_out` out 32: HI register.
- `lo_out` out 32: LO register.
- `busy_out` out 1: iterative operation in flight.
- `done_out` out 1: one-cycle pulse when HI/LO were written by an iterative operation.
- `stall_out` out 1: combinational; `start_in & busy_out & (code ∈ mul/div set)`.

## Operation
- Mul/div code set:
  - 010000 mfhi
  - 010001 mthi
  - 010010 mflo
  - 010011 mtlo
  - 011000 mult
  - 011001 multu
  - 011010 div
  - 011011 divu
- Codes outside this set are ignored; there is no state change.
- Accept: `start_in=1`, `busy_out=0`, and the code is in the set. While busy, commands are not accepted. Upstream holds the instruction while `stall_out=1`.
- mthi/mtlo: HI (or LO) is written with `rs_in` on the accept edge. There is no busy phase.
- mfhi/mflo: read only. When not stalled, `result_out` is valid in the same cycle.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - On mult/multu, latch operands and go to MUL.
  - On div/divu, latch operands and go to DIV.
  - Clear the 6-bit iteration counter.
  - For signed ops, latch |rs| and |rt|. Record `neg_q = rs[31]^rt[31]` and `neg_r = rs[31]`.
  - For unsigned ops, both sign flags are 0.
- MUL: shift-add, one multiplier bit per cycle, 32 cycles into a 64-bit accumulator, then go to FIX.
- DIV: restoring division, one quotient bit per cycle, 32 cycles, giving a 32-bit remainder and quotient, then go to FIX.
- FIX:
  - For mult, apply two's-complement negation of the 64-bit product if `neg_q`.
  - For div, negate the quotient if `neg_q` and the remainder if `neg_r`.
  - Write HI/LO: product[63:32]/[31:0] for multiply; remainder/quotient for divide.
  - Pulse `done_out` and return to IDLE.
- Divide by zero (`rt_in=0`): LO=0xFFFFFFFF and HI=original `rs_in`, for both div and divu. Latency is the same as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm.
- Widths: all magnitudes are treated as unsigned 32-bit. |0x80000000| = 0x80000000.

## Timing
- Reset (`reset_n=0` at a rising edge):
  - HI=0, LO=0, state=IDLE.
  - `busy_out=0`, `done_out=0`, counter=0.
  - `result_out`/`stall_out` follow combinationally.
- Reset mid-operation aborts the operation. HI/LO go to 0 and nothing partial is written.
- Iterative latency, with the accept edge as E0:
  - `busy_out`=1 from after E0 through the cycle before E33.
  - The 32 iteration edges are E1..E32.
  - The FIX write occurs at E33. `busy_out`=0 and `done_out`=1 for the cycle after E33.
  - A new command is accepted at E34 at the earliest. mfhi in the cycle after E33 returns the new HI.
- `done_out` is high for exactly one cycle per iterative op. It never fires for mthi/mtlo.
- While busy, `start_in` with a non-set code has no effect and asserts no stall.
- HI/LO are stable and unchanged between accept and the FIX write.

## Test plan
- mult with rs=7, rt=0xFFFFFFFD (−3) → HI=0xFFFFFFFF, LO=0xFFFFFFEB. `done_out` is asserted exactly 34 cycles after the accept edge. `busy_out` is high for 33 cycles.
- multu with rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Signed and unsigned divides:
  - div rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 100/7 → LO=14, HI=2.
- Divide edge cases:
  - div 5/0 → LO=0xFFFFFFFF, HI=5.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Stall behaviour:
  - mthi 0x12345678 → mfhi next cycle returns 0x12345678 with `stall_out=0`.
  - mflo issued during a busy mult → `stall_out=1` until busy clears; then `result_out` returns the new LO.
- Reset during a busy div at iteration 10 → HI=LO=0, `busy_out=0`, `done_out` never pulses. A subsequent divu 9/3 yields LO=3, HI=0.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Command/result bundle between the EX-stage controller and the multiply/divide unit.
// The controller side uses the master modport and the unit uses the slave modport.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start_in;
  logic [5:0]       ALUSelect_in;
  logic [WIDTH-1:0] rs_in;
  logic [WIDTH-1:0] rt_in;
  logic [WIDTH-1:0] result_out;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy_out;
  logic             done_out;
  logic             stall_out;

  modport master (
    output start_in, ALUSelect_in, rs_in, rt_in,
    input  result_out, hi_out, lo_out, busy_out, done_out, stall_out
  );

  modport slave (
    input  start_in, ALUSelect_in, rs_in, rt_in,
    output result_out, hi_out, lo_out, busy_out, done_out, stall_out
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with a FIX state that restores signs.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  bus
);

  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MTHI = 6'b010001;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_MTLO = 6'b010011;
  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opB_q, opB_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 isDiv_q, isDiv_d;
  logic                 negQ_q, negQ_d;
  logic                 negR_q, negR_d;
  logic                 divZero_q, divZero_d;
  logic                 done_q, done_d;

  logic [5:0]           sel;
  logic                 inSet, isIter, accept, signedOp;
  logic [WIDTH-1:0]     absA, absB, fixQuo, fixRem;
  logic [WIDTH:0]       mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0]   fixProd;

  assign sel      = bus.ALUSelect_in;
  assign inSet    = (sel[5:2] == 4'b0100) || (sel[5:2] == 4'b0110);
  assign isIter   = (sel[5:2] == 4'b0110);
  assign accept   = bus.start_in && inSet && (state_q == IDLE);
  assign signedOp = !sel[0];
  assign absA     = (signedOp && bus.rs_in[WIDTH-1]) ? -bus.rs_in : bus.rs_in;
  assign absB     = (signedOp && bus.rt_in[WIDTH-1]) ? -bus.rt_in : bus.rt_in;

  // acc_q holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opB_q};
  assign fixProd  = negQ_q ? -acc_q : acc_q;
  assign fixRem   = negR_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fixQuo   = divZero_q ? '1 : (negQ_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && isIter) state_d = sel[1] ? DIV : MUL;
      MUL:  if (cnt_q == LAST_ITER) state_d = FIX;
      DIV:  if (cnt_q == LAST_ITER) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opB_d     = opB_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    isDiv_d   = isDiv_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    divZero_d = divZero_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (isIter) begin
            isDiv_d   = sel[1];
            negQ_d    = signedOp && (bus.rs_in[WIDTH-1] ^ bus.rt_in[WIDTH-1]);
            negR_d    = signedOp && bus.rs_in[WIDTH-1];
            divZero_d = (bus.rt_in == '0);
            acc_d     = {{WIDTH{1'b0}}, absA};
            opB_d     = absB;
          end else if (sel == OP_MTHI) begin
            hi_d = bus.rs_in;
          end else if (sel == OP_MTLO) begin
            lo_d = bus.rs_in;
          end
        end
      end
      MUL: begin
        acc_d = {mulSum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
      end
      DIV: begin
        // Borrow out of the trial subtract means the divisor did not fit: restore
        if (divDiff[WIDTH]) begin
          acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 6'd1;
      end
      FIX: begin
        hi_d   = isDiv_q ? fixRem : fixProd[2*WIDTH-1:WIDTH];
        lo_d   = isDiv_q ? fixQuo : fixProd[WIDTH-1:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opB_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      isDiv_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opB_q     <= opB_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      isDiv_q   <= isDiv_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      divZero_q <= divZero_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    bus.busy_out  = (state_q != IDLE);
    bus.done_out  = done_q;
    bus.hi_out    = hi_q;
    bus.lo_out    = lo_q;
    bus.stall_out = bus.start_in && (state_q != IDLE) && inSet;
    if (sel == OP_MFHI)      bus.result_out = hi_q;
    else if (sel == OP_MFLO) bus.result_out = lo_q;
    else                     bus.result_out = '0;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expectations from an arithmetic reference model are
// queued at issue time and a monitor compares them against done pulses and register reads.
module tb_mul_div_unit;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] iterQ[$];
  logic [31:0] readQ[$];
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isIterCode(input logic [5:0] c);
    return (c == MULT) || (c == MULTU) || (c == DIV) || (c == DIVU);
  endfunction

  function automatic bit inSetCode(input logic [5:0] c);
    return isIterCode(c) || (c == MFHI) || (c == MTHI) || (c == MFLO) || (c == MTLO);
  endfunction

  // Reference result {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] refOp(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int sq, sr;
    case (c)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      MULTU: return {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Monitor: every done pulse and every unstalled read consumes one queued expectation
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.done_out) begin
        if (iterQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'(bus.done_out), 64'd0);
        end else begin
          e = iterQ.pop_front();
          checkOutput("doneHi", 64'(bus.hi_out), 64'(e[63:32]));
          checkOutput("doneLo", 64'(bus.lo_out), 64'(e[31:0]));
        end
      end
      if (reset_n && bus.start_in && !bus.stall_out &&
          (bus.ALUSelect_in == MFHI || bus.ALUSelect_in == MFLO)) begin
        if (readQ.size() == 0) begin
          checkOutput("unexpectedRead", 64'(bus.result_out), 64'hx);
        end else begin
          checkOutput("readResult", 64'(bus.result_out), 64'(readQ.pop_front()));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Update the model, queue the expectation, then present the command for one accept edge
  task automatic applyStimulus(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (isIterCode(c)) begin
      r = refOp(c, a, b);
      iterQ.push_back(r);
      mHi = r[63:32];
      mLo = r[31:0];
    end else if (c == MTHI) mHi = a;
    else if (c == MTLO) mLo = a;
    else if (c == MFHI) readQ.push_back(mHi);
    else if (c == MFLO) readQ.push_back(mLo);
    @(posedge clk);
    #1;
    bus.start_in = 1'b1;
    bus.ALUSelect_in = c;
    bus.rs_in = a;
    bus.rt_in = b;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    bus.ALUSelect_in = 6'b000000;
  endtask

  task automatic waitDone(output int cycles, output int busyCnt);
    cycles = 0;
    busyCnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.busy_out) busyCnt++;
      if (bus.done_out) break;
    end
    if (!bus.done_out) checkOutput("doneTimeout", 64'(bus.done_out), 64'd1);
  endtask

  task automatic runOp(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    int cyc, bc;
    applyStimulus(c, a, b);
    if (isIterCode(c)) begin
      waitDone(cyc, bc);
      checkOutput("doneLatency", 64'(cyc), 64'd34);
      checkOutput("busyCycles", 64'(bc), 64'd33);
    end
  endtask

  task automatic runDirected(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expHi, input logic [31:0] expLo);
    runOp(c, a, b);
    checkOutput("directedHi", 64'(bus.hi_out), 64'(expHi));
    checkOutput("directedLo", 64'(bus.lo_out), 64'(expLo));
  endtask

  initial begin
    int cyc, bc, stallCnt, r;
    logic [5:0] c;
    logic [31:0] a, b;

    bus.start_in = 1'b0;
    bus.ALUSelect_in = 6'b000000;
    bus.rs_in = '0;
    bus.rt_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetHi", 64'(bus.hi_out), 64'd0);
    checkOutput("resetLo", 64'(bus.lo_out), 64'd0);
    checkOutput("resetBusy", 64'(bus.busy_out), 64'd0);
    checkOutput("resetDone", 64'(bus.done_out), 64'd0);
    checkOutput("resetStall", 64'(bus.stall_out), 64'd0);
    checkOutput("resetResult", 64'(bus.result_out), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    runDirected(MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runDirected(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runDirected(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runDirected(DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    runDirected(DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    runDirected(DIVU, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    runDirected(DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // divu 100/7 with a non-set code presented while busy
    applyStimulus(DIVU, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    bus.start_in = 1'b1;
    bus.ALUSelect_in = 6'b100000;
    @(negedge clk);
    checkOutput("foreignNoStall", 64'(bus.stall_out), 64'd0);
    checkOutput("foreignBusy", 64'(bus.busy_out), 64'd1);
    @(posedge clk);
    #1 bus.start_in = 1'b0;
    waitDone(cyc, bc);
    checkOutput("divuHi", 64'(bus.hi_out), 64'd2);
    checkOutput("divuLo", 64'(bus.lo_out), 64'd14);

    // mthi then mfhi in the very next cycle
    applyStimulus(MTHI, 32'h12345678, 32'd0);
    bus.start_in = 1'b1;
    bus.ALUSelect_in = MFHI;
    readQ.push_back(mHi);
    @(negedge clk);
    checkOutput("mfhiNoStall", 64'(bus.stall_out), 64'd0);
    checkOutput("mfhiValue", 64'(bus.result_out), 64'h12345678);
    checkOutput("mthiNoDone", 64'(bus.done_out), 64'd0);
    @(posedge clk);
    #1 bus.start_in = 1'b0;

    // mflo held against a busy mult until the stall releases
    applyStimulus(MULT, $urandom, $urandom);
    @(posedge clk);
    #1;
    bus.start_in = 1'b1;
    bus.ALUSelect_in = MFLO;
    readQ.push_back(mLo);
    stallCnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.stall_out) break;
      stallCnt++;
    end
    checkOutput("stallCycles", 64'(stallCnt), 64'd32);
    checkOutput("stallReleaseLo", 64'(bus.result_out), 64'(mLo));
    @(posedge clk);
    #1 bus.start_in = 1'b0;

    // Reset after the tenth iteration edge of a div aborts it entirely
    applyStimulus(DIV, 32'h7FFF1234, 32'd13);
    void'(iterQ.pop_back());
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    mHi = '0;
    mLo = '0;
    @(negedge clk);
    checkOutput("abortHi", 64'(bus.hi_out), 64'd0);
    checkOutput("abortLo", 64'(bus.lo_out), 64'd0);
    checkOutput("abortBusy", 64'(bus.busy_out), 64'd0);
    repeat (40) @(posedge clk);
    runDirected(DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

    // Randomised mix of all codes, including foreign codes and zero divisors
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (r == 1 && $urandom_range(0, 1) == 1) a = {1'b1, a[30:0]};
      case (r)
        0: c = MULT;
        1: c = MULTU;
        2: c = DIV;
        3: c = DIVU;
        4: c = MTHI;
        5: c = MTLO;
        6: c = MFHI;
        7: c = MFLO;
        8: begin
          c = 6'($urandom_range(0, 63));
          while (inSetCode(c)) c = 6'($urandom_range(0, 63));
        end
        default: begin
          c = ($urandom_range(0, 1) == 1) ? DIV : DIVU;
          b = '0;
        end
      endcase
      runOp(c, a, b);
    end
    runOp(MFHI, 32'd0, 32'd0);
    runOp(MFLO, 32'd0, 32'd0);

    repeat (5) @(posedge clk);
    checkOutput("iterQueueDrained", 64'(iterQ.size()), 64'd0);
    checkOutput("readQueueDrained", 64'(readQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
